// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, ALU op-code encodings and op-class helpers used by
// the ALU arbiter and the ALU it feeds.
package alu_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned OPW  = 4;

  localparam logic [OPW-1:0] ALU_ADD = 4'b0000;
  localparam logic [OPW-1:0] ALU_SUB = 4'b0001;
  localparam logic [OPW-1:0] ALU_AND = 4'b0010;
  localparam logic [OPW-1:0] ALU_OR  = 4'b0011;
  localparam logic [OPW-1:0] ALU_XOR = 4'b0100;
  localparam logic [OPW-1:0] ALU_SLL = 4'b0101;
  localparam logic [OPW-1:0] ALU_SRL = 4'b0110;
  localparam logic [OPW-1:0] ALU_SRA = 4'b0111;
  localparam logic [OPW-1:0] ALU_BEQ = 4'b1000;
  localparam logic [OPW-1:0] ALU_BNE = 4'b1001;
  localparam logic [OPW-1:0] ALU_BLT = 4'b1010;
  localparam logic [OPW-1:0] ALU_BGE = 4'b1011;
  localparam logic [OPW-1:0] ALU_LUI = 4'b1111;

  function automatic logic is_branch_op(input logic [OPW-1:0] op);
    return (op >= ALU_BEQ) && (op <= ALU_BGE);
  endfunction

  function automatic logic is_shift_op(input logic [OPW-1:0] op);
    return (op >= ALU_SLL) && (op <= ALU_SRA);
  endfunction

  function automatic logic is_illegal_op(input logic [OPW-1:0] op);
    return (op >= 4'b1100) && (op <= 4'b1110);
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// alu_arbiter_alu: the core's single combinational ALU.
//   op     : ALU op code
//   op_a   : first operand
//   op_b   : second operand (shift amount for shift ops)
//   res_c  : arithmetic/logic result, 0 for branch and illegal ops
//   branch : branch-taken flag, 0 for non-branch ops
module alu_arbiter_alu
  import alu_pkg::*;
(
  input  logic [OPW-1:0]  op,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [XLEN-1:0] res_c,
  output logic            branch
);

  always_comb begin
    res_c  = '0;
    branch = 1'b0;
    case (op)
      ALU_ADD: res_c = op_a + op_b;
      ALU_SUB: res_c = op_a - op_b;
      ALU_AND: res_c = op_a & op_b;
      ALU_OR:  res_c = op_a | op_b;
      ALU_XOR: res_c = op_a ^ op_b;
      ALU_SLL: res_c = op_a << op_b;
      ALU_SRL: res_c = op_a >> op_b;
      ALU_SRA: res_c = XLEN'($signed(op_a) >>> op_b);
      ALU_BEQ: branch = (op_a == op_b);
      ALU_BNE: branch = (op_a != op_b);
      ALU_BLT: branch = ($signed(op_a) <  $signed(op_b));
      ALU_BGE: branch = ($signed(op_a) >= $signed(op_b));
      ALU_LUI: res_c = op_b;
      default: begin
        res_c  = '0;
        branch = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-port round-robin arbiter sharing one ALU between the
// execute stage (port 0) and the branch/address unit (port 1). The granted
// port's sanitised operands drive the ALU; its result is registered into a
// single output slot with valid/ready backpressure.
//   clk, rst_n                    : clock, synchronous active-low reset
//   reqN_valid/ready              : request handshake per port
//   reqN_opA/opB/op               : request payload per port
//   rsp_valid/ready               : output slot handshake
//   rsp_id, rsp_resC, rsp_branch  : issuing port, result, branch-taken flag
module alu_arbiter
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [XLEN-1:0] req0_opA,
  input  logic [XLEN-1:0] req0_opB,
  input  logic [OPW-1:0]  req0_op,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [XLEN-1:0] req1_opA,
  input  logic [XLEN-1:0] req1_opB,
  input  logic [OPW-1:0]  req1_op,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [XLEN-1:0] rsp_resC,
  output logic            rsp_branch
);

  logic            last_grant_q, last_grant_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_id_q, rsp_id_d;
  logic [XLEN-1:0] rsp_resC_q, rsp_resC_d;
  logic            rsp_branch_q, rsp_branch_d;

  logic            slot_free;
  logic            grant_vld;
  logic            grant;
  logic            accept;
  logic [OPW-1:0]  alu_op;
  logic [XLEN-1:0] alu_a, alu_b;
  logic [XLEN-1:0] alu_res;
  logic            alu_br;

  // Grant depends only on valids and slot state, never on payload.
  always_comb begin
    slot_free = !rsp_valid_q || rsp_ready;
    grant_vld = req0_valid || req1_valid;
    if (req0_valid && req1_valid) grant = !last_grant_q;
    else                          grant = req1_valid;
    accept     = grant_vld && slot_free;
    req0_ready = accept && !grant;
    req1_ready = accept && grant;
  end

  always_comb begin
    alu_op = grant ? req1_op  : req0_op;
    alu_a  = grant ? req1_opA : req0_opA;
    alu_b  = grant ? req1_opB : req0_opB;
    // Shift amount limited to 0..31 by clearing the upper operand bits.
    if (is_shift_op(alu_op)) alu_b[XLEN-1:5] = '0;
  end

  alu_arbiter_alu u_alu (
    .op     (alu_op),
    .op_a   (alu_a),
    .op_b   (alu_b),
    .res_c  (alu_res),
    .branch (alu_br)
  );

  always_comb begin
    last_grant_d = last_grant_q;
    rsp_valid_d  = rsp_valid_q && !rsp_ready;
    rsp_id_d     = rsp_id_q;
    rsp_resC_d   = rsp_resC_q;
    rsp_branch_d = rsp_branch_q;
    if (accept) begin
      last_grant_d = grant;
      rsp_valid_d  = 1'b1;
      rsp_id_d     = grant;
      rsp_resC_d   = '0;
      rsp_branch_d = 1'b0;
      if (is_branch_op(alu_op))      rsp_branch_d = alu_br;
      else if (!is_illegal_op(alu_op)) rsp_resC_d = alu_res;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_resC_q   <= '0;
      rsp_branch_q <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_resC_q   <= rsp_resC_d;
      rsp_branch_q <= rsp_branch_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_resC   = rsp_resC_q;
  assign rsp_branch = rsp_branch_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter. A negedge monitor models
// the grant/slot behaviour, pushes expected results on acceptance and pops
// them when the DUT's slot drains; directed sequences add targeted checks.
module tb_alu_arbiter;
  import alu_pkg::*;

  typedef struct packed {
    logic            id;
    logic [XLEN-1:0] res;
    logic            br;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            r0v = 1'b0, r1v = 1'b0;
  logic [XLEN-1:0] r0a = '0, r0b = '0, r1a = '0, r1b = '0;
  logic [OPW-1:0]  r0op = '0, r1op = '0;
  logic            rsp_rdy = 1'b0;
  logic            req0_ready, req1_ready;
  logic            rsp_valid, rsp_id, rsp_branch;
  logic [XLEN-1:0] rsp_resC;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;
  logic m_valid = 1'b0;
  logic m_last = 1'b1;
  logic acc0 = 1'b0, acc1 = 1'b0;

  alu_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (r0v),
    .req0_ready (req0_ready),
    .req0_opA   (r0a),
    .req0_opB   (r0b),
    .req0_op    (r0op),
    .req1_valid (r1v),
    .req1_ready (req1_ready),
    .req1_opA   (r1a),
    .req1_opB   (r1b),
    .req1_op    (r1op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_rdy),
    .rsp_id     (rsp_id),
    .rsp_resC   (rsp_resC),
    .rsp_branch (rsp_branch)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  function automatic exp_t ref_op(input logic id, input logic [3:0] op,
                                  input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   sh;
    e.id = id; e.res = 32'd0; e.br = 1'b0;
    sh = int'(b % 32);
    case (op)
      4'd0:  e.res = a + b;
      4'd1:  e.res = a + (~b + 32'd1);
      4'd2:  e.res = a & b;
      4'd3:  e.res = a | b;
      4'd4:  e.res = a ^ b;
      4'd5:  e.res = a << sh;
      4'd6:  e.res = a >> sh;
      4'd7:  e.res = (a >> sh) | ((a[31] && sh != 0) ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
      4'd8:  e.br = (a == b);
      4'd9:  e.br = (a != b);
      4'd10: e.br = (int'(a) < int'(b));
      4'd11: e.br = !(int'(a) < int'(b));
      4'd15: e.res = b;
      default: ;
    endcase
    return e;
  endfunction

  // Reference model of grant + slot, sampled away from the active edge.
  always @(negedge clk) begin
    logic free, gv, g, e0, e1;
    exp_t e;
    acc0 = 1'b0;
    acc1 = 1'b0;
    if (!rst_n) begin
      sb.delete();
      m_valid = 1'b0;
      m_last  = 1'b1;
    end else begin
      free = !m_valid || rsp_rdy;
      gv   = r0v || r1v;
      g    = (r0v && r1v) ? !m_last : r1v;
      e0   = free && gv && !g;
      e1   = free && gv && g;
      check("rdy0", 32'(req0_ready), 32'(e0));
      check("rdy1", 32'(req1_ready), 32'(e1));
      check("rsp_valid", 32'(rsp_valid), 32'(m_valid));
      if (rsp_valid && rsp_rdy) begin
        if (sb.size() == 0) check("sb_underflow", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          check("sb_id", 32'(rsp_id), 32'(e.id));
          check("sb_res", rsp_resC, e.res);
          check("sb_br", 32'(rsp_branch), 32'(e.br));
        end
      end
      if (e0) sb.push_back(ref_op(1'b0, r0op, r0a, r0b));
      if (e1) sb.push_back(ref_op(1'b1, r1op, r1a, r1b));
      if (e0 || e1) m_last = g;
      m_valid = (e0 || e1) ? 1'b1 : (rsp_rdy ? 1'b0 : m_valid);
      acc0 = e0;
      acc1 = e1;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  // Drive one request on a port, wait for acceptance, then drop valid.
  task automatic issue(input logic port, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    bit done;
    done = 1'b0;
    if (port) begin r1v = 1'b1; r1op = op; r1a = a; r1b = b; end
    else      begin r0v = 1'b1; r0op = op; r0a = a; r0b = b; end
    for (int i = 0; i < 20 && !done; i++) begin
      sample();
      done = port ? acc1 : acc0;
      cyc();
    end
    if (!done) check("issue_timeout", 32'd0, 32'd1);
    r0v = 1'b0;
    r1v = 1'b0;
  endtask

  task automatic pick(output logic [3:0] op, output logic [31:0] a, output logic [31:0] b);
    op = 4'($urandom_range(0, 15));
    a  = $urandom;
    b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
    if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 70));
  endtask

  initial begin
    rst_n = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    sample();
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_id", 32'(rsp_id), 32'd0);
    check("rst_res", rsp_resC, 32'd0);
    check("rst_br", 32'(rsp_branch), 32'd0);
    cyc();

    // Single add on port 0.
    rsp_rdy = 1'b1;
    issue(1'b0, ALU_ADD, 32'd5, 32'd7);
    sample();
    check("add_valid", 32'(rsp_valid), 32'd1);
    check("add_id", 32'(rsp_id), 32'd0);
    check("add_res", rsp_resC, 32'd12);
    check("add_br", 32'(rsp_branch), 32'd0);
    cyc();

    // Tie from reset alternates 0,1,0,1.
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    r0v = 1'b1; r0op = ALU_ADD; r0a = 32'd1; r0b = 32'd1;
    r1v = 1'b1; r1op = ALU_SUB; r1a = 32'd9; r1b = 32'd4;
    for (int i = 0; i < 4; i++) begin
      sample();
      check("tie_grant", 32'(acc1), 32'(i % 2));
      if (i > 0) check("tie_id", 32'(rsp_id), 32'((i - 1) % 2));
      cyc();
    end
    r0v = 1'b0; r1v = 1'b0;
    cyc(); cyc();

    // Backpressure: slot held for 4 cycles, then drain+accept together.
    rsp_rdy = 1'b0;
    issue(1'b0, ALU_AND, 32'hF0, 32'h3C);
    r0v = 1'b1; r0op = ALU_OR;  r0a = 32'hF0; r0b = 32'h0F;
    r1v = 1'b1; r1op = ALU_XOR; r1a = 32'hFF; r1b = 32'h0F;
    for (int i = 0; i < 4; i++) begin
      sample();
      check("bp_rdy", {30'd0, req1_ready, req0_ready}, 32'd0);
      check("bp_hold", rsp_resC, 32'h30);
      check("bp_valid", 32'(rsp_valid), 32'd1);
      cyc();
    end
    rsp_rdy = 1'b1;
    sample();
    check("bp_acc1", 32'(acc1), 32'd1);
    cyc();
    r1v = 1'b0;
    sample();
    check("bp_keep_valid", 32'(rsp_valid), 32'd1);
    check("bp_id", 32'(rsp_id), 32'd1);
    check("bp_res", rsp_resC, 32'hF0);
    check("bp_acc0", 32'(acc0), 32'd1);
    cyc();
    r0v = 1'b0;

    issue(1'b1, ALU_SLL, 32'd1, 32'h21);
    sample();
    check("sll_res", rsp_resC, 32'd2);
    cyc();
    issue(1'b0, ALU_BLT, 32'hFFFF_FFFF, 32'd1);
    sample();
    check("blt_br", 32'(rsp_branch), 32'd1);
    check("blt_res", rsp_resC, 32'd0);
    cyc();
    issue(1'b1, 4'b1101, 32'd123, 32'd456);
    sample();
    check("ill_valid", 32'(rsp_valid), 32'd1);
    check("ill_res", rsp_resC, 32'd0);
    check("ill_br", 32'(rsp_branch), 32'd0);
    cyc();

    // Reset with a held result.
    rsp_rdy = 1'b0;
    issue(1'b0, ALU_ADD, 32'd2, 32'd3);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    sample();
    check("rst_mid_valid", 32'(rsp_valid), 32'd0);
    cyc();
    rsp_rdy = 1'b1;
    r0v = 1'b1; r0op = ALU_XOR; r0a = 32'h55; r0b = 32'hAA;
    r1v = 1'b1; r1op = ALU_LUI; r1a = 32'h0;  r1b = 32'h1234_5000;
    sample();
    check("rst_tie", 32'(acc0), 32'd1);
    cyc();
    r0v = 1'b0;
    cyc();
    r1v = 1'b0;

    // Random traffic with random backpressure.
    for (int n = 0; n < 400; n++) begin
      cyc();
      rsp_rdy = ($urandom_range(0, 3) != 0);
      if (!r0v || acc0) begin
        r0v = $urandom_range(0, 1);
        pick(r0op, r0a, r0b);
      end
      if (!r1v || acc1) begin
        r1v = $urandom_range(0, 1);
        pick(r1op, r1a, r1b);
      end
    end
    cyc();
    r0v = 1'b0; r1v = 1'b0; rsp_rdy = 1'b1;
    cyc(); cyc(); cyc();
    sample();
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port round-robin arbiter that shares the core's single combinational ALU between the execute stage (port 0) and the branch/address unit (port 1). Each port issues one operation per valid/ready handshake. The block sanitises operands and registers the ALU result into a single output slot with valid/ready backpressure. It sits between the decode/issue logic and the ALU instance, and is the only driver of the ALU inputs.

## Interface
- XLEN, 32, operand/result width
- OPW, 4, ALU op code width
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset, synchronous, active-low
- req0_valid / req1_valid  in  1  request present on port 0 / 1
- req0_ready / req1_ready  out  1  request accepted this cycle (combinational)
- req0_opA, req0_opB / req1_opA, req1_opB  in  XLEN  operands
- req0_op / req1_op  in  OPW  ALU op code
- rsp_valid  out  1  output slot holds a result
- rsp_ready  in  1  consumer takes the result this cycle
- rsp_id  out  1  port that issued the held result
- rsp_resC  out  XLEN  registered result
- rsp_branch  out  1  registered branch-taken flag

## Operation
- Op codes: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 sll, 0110 srl, 0111 sra, 1000 beq, 1001 bne, 1010 blt (signed), 1011 bge (signed), 1111 pass opB (lui). Codes 1100–1110 are illegal.
- slot_free = !rsp_valid || rsp_ready.
- Grant rules:
  - Only one port valid: that port is granted.
  - Both ports valid: the port not granted at the last accepted transfer wins.
  - No valid requests: no grant.
- reqX_ready = slot_free && grant==X. At most one ready is high per cycle.
- The round-robin pointer last_grant updates only on an accepted transfer (valid && ready). It holds while the slot is stalled.
- Operand sanitising before the ALU:
  - Shift ops (0101–0111): opB[XLEN-1:5] is forced to 0, so the shift amount is 0..31.
  - All other ops: operands pass unchanged.
- Result capture on an accepted transfer:
  - Arithmetic/logic ops and 1111: rsp_resC = ALU result, rsp_branch = 0.
  - Branch ops (1000–1011): rsp_branch = ALU branch flag, rsp_resC = 0.
  - Illegal ops: rsp_resC = 0, rsp_branch = 0. The transfer is still accepted and answered.
- rsp_id = granted port.
- Slot update:
  - rsp_valid sets on acceptance.
  - rsp_valid clears on rsp_valid && rsp_ready when no new acceptance occurs in the same cycle.
  - Drain and accept in the same cycle: the new result overwrites the slot, and rsp_valid stays 1.
- While rsp_valid && !rsp_ready, rsp_id, rsp_resC and rsp_branch are held stable.
- A request whose valid is high but is not granted must keep valid and its payload stable until accepted. The block does not check this.

## Timing
- Reset (rst_n=0 at a rising edge):
  - rsp_valid=0, rsp_id=0, rsp_resC=0, rsp_branch=0.
  - last_grant=1, so port 0 wins the first tie.
  - Requests are ignored during reset.
- Latency: request accepted at edge N gives rsp_valid=1 with its data after edge N; the result is visible in cycle N+1.
- Throughput: one operation per cycle when rsp_ready is held high.
- Ready depends combinationally on req*_valid, rsp_valid and rsp_ready only, never on the operands.
- Starvation bound: with the slot draining, a continuously valid port waits at most 1 accepted transfer of the other port.
- Reset mid-operation: a held result is discarded, and no response is produced for it.

## Structure
- Package alu_pkg holds:
  - XLEN and OPW.
  - Op-code localparams: ALU_ADD … ALU_BGE, ALU_LUI.
  - Helper functions is_branch_op, is_shift_op and is_illegal_op.
- One sub-module: the core's existing ALU, instantiated once. The arbiter drives its opA/opB/op inputs from the granted port's sanitised payload.
- Remaining logic: grant mux, 1-bit last_grant register, output slot registers.

## Test plan
- Single op: req0 add 5+7 with rsp_ready=1 → req0_ready=1; next cycle rsp_valid=1, rsp_id=0, rsp_resC=12, rsp_branch=0.
- Tie from reset: both ports valid every cycle with rsp_ready=1 → grants alternate 0,1,0,1. rsp_id follows the same sequence one cycle later.
- Backpressure: rsp_ready=0 after one acceptance → both readys low, and the slot holds its value for 4 cycles. Then rsp_ready=1 → same-cycle drain+accept, rsp_valid stays 1.
- Shift sanitising: req1 sll opA=1, opB=0x00000021 → rsp_resC=0x00000002 (amount 1, not 33).
- Branch/illegal:
  - blt opA=0xFFFFFFFF, opB=1 → rsp_branch=1, rsp_resC=0.
  - op 1101 → rsp_valid=1, rsp_resC=0, rsp_branch=0.
- Reset mid-operation: slot full with rsp_ready=0, then assert rst_n=0 for 1 cycle → rsp_valid=0. The next tie grants port 0.
